// File: rtl/snake_pkg.sv
// snake_pkg: shared types and grid defaults for the SPI command controller
package snake_pkg;
    localparam int GRID_W_DEF = 32;
    localparam int GRID_H_DEF = 24;
    typedef enum logic [3:0] {
        OP_NOP        = 4'h0,
        OP_WRITE_TILE = 4'h1,
        OP_CLEAR      = 4'h2,
        OP_SET_SCORE  = 4'h3
    } opcode_t;
    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_WRITE,
        S_CLEAR
    } state_t;
    typedef struct packed {
        logic [7:0] command;
        logic [7:0] databyte1;
        logic [7:0] databyte2;
    } frame_t;
endpackage

// File: rtl/spi_cmd_ctrl_sync_fall.sv
// sync_fall: two-flop synchronizer with a falling-edge pulse on the synchronized level
module sync_fall (
    input  logic clk,
    input  logic nreset,
    input  logic d,
    output logic fall
);
    logic [2:0] sr;
    always_ff @(posedge clk)
        if (!nreset) sr <= '0;
        else sr <= {sr[1:0], d};
    assign fall = sr[2] & ~sr[1];
endmodule

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: decodes synchronized SPI frames into framebuffer writes with one frame of buffering
module spi_cmd_ctrl import snake_pkg::*; #(
    parameter int GRID_W = GRID_W_DEF,
    parameter int GRID_H = GRID_H_DEF,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              cs,
    input  logic [7:0]        command,
    input  logic [7:0]        databyte1,
    input  logic [7:0]        databyte2,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [3:0]        wr_data,
    output logic [15:0]       score,
    output logic              busy,
    output logic              overrun,
    output logic [7:0]        bad_cmd_count
);
    localparam int N_TILES = GRID_W * GRID_H;
    logic ev, pend_v, accept, last, bad;
    logic [3:0] op;
    frame_t cur, pend, incoming;
    state_t state, state_nx;
    sync_fall u_sync (.clk(clk), .nreset(nreset), .d(cs), .fall(ev));
    assign incoming = {command, databyte1, databyte2};
    assign op       = cur.command[7:4];
    assign accept   = wr_valid && wr_ready;
    assign last     = wr_addr == ADDR_W'(N_TILES - 1);
    assign bad      = op > OP_SET_SCORE || (op == OP_WRITE_TILE &&
                      (int'(cur.databyte1) >= GRID_W || int'(cur.databyte2) >= GRID_H));
    assign busy     = state != S_IDLE || pend_v;
    always_ff @(posedge clk)
        if (!nreset) state <= S_IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (pend_v || ev) state_nx = S_DECODE;
            S_DECODE: state_nx = bad ? S_IDLE : op == OP_WRITE_TILE ? S_WRITE :
                                 op == OP_CLEAR ? S_CLEAR : S_IDLE;
            S_WRITE:  if (accept) state_nx = S_IDLE;
            S_CLEAR:  if (accept && last) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end
    always_ff @(posedge clk)
        if (!nreset) begin
            cur           <= '0;
            pend          <= '0;
            pend_v        <= 1'b0;
            overrun       <= 1'b0;
            wr_valid      <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            score         <= '0;
            bad_cmd_count <= '0;
        end else begin
            if (state == S_IDLE && (pend_v || ev)) cur <= pend_v ? pend : incoming;
            // a held frame is consumed in IDLE, so a new arrival then refills it
            if (ev && (state != S_IDLE || pend_v)) begin
                if (state != S_IDLE && pend_v) overrun <= 1'b1;
                else begin
                    pend   <= incoming;
                    pend_v <= 1'b1;
                end
            end else if (state == S_IDLE) pend_v <= 1'b0;
            if (state == S_DECODE) begin
                if (bad && bad_cmd_count != 8'hff) bad_cmd_count <= bad_cmd_count + 8'd1;
                if (!bad && op == OP_SET_SCORE) score <= {cur.databyte1, cur.databyte2};
                wr_addr <= op == OP_CLEAR ? '0 :
                           ADDR_W'(cur.databyte2) * ADDR_W'(GRID_W) + ADDR_W'(cur.databyte1);
                wr_data <= cur.command[3:0];
            end else if (state == S_CLEAR && accept) wr_addr <= wr_addr + ADDR_W'(1);
            wr_valid <= (state == S_WRITE && !accept) || (state == S_CLEAR && !(accept && last));
        end
endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb_spi_cmd_ctrl: randomized and directed checks of spi_cmd_ctrl against a frame-level model
module tb_spi_cmd_ctrl;
    localparam int GW = 32, GH = 24, AW = 10;
    logic clk = 0, nreset = 0, cs = 0, wr_ready = 0;
    logic [7:0] command = 0, databyte1 = 0, databyte2 = 0;
    logic wr_valid, busy, overrun;
    logic [AW-1:0] wr_addr;
    logic [3:0] wr_data;
    logic [15:0] score;
    logic [7:0] bad_cmd_count;
    int total = 0, bad = 0;
    int ready_mode = 0;
    logic ready_hold = 0;
    logic [13:0] log_q[$], exp_q[$];
    logic [15:0] exp_score = 0;
    int exp_bad = 0;

    spi_cmd_ctrl #(.GRID_W(GW), .GRID_H(GH), .ADDR_W(AW)) dut (
        .clk(clk), .nreset(nreset), .cs(cs), .command(command), .databyte1(databyte1),
        .databyte2(databyte2), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .score(score), .busy(busy), .overrun(overrun),
        .bad_cmd_count(bad_cmd_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin
        #2;
        wr_ready = ready_mode == 0 ? ready_hold : ready_mode == 1 ? 1'($urandom) : ~wr_ready;
    end
    always @(negedge clk) if (nreset && wr_valid && wr_ready) log_q.push_back({wr_addr, wr_data});

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] x, input logic [7:0] y);
        cs = 1; command = c; databyte1 = x; databyte2 = y;
        repeat (3) tick();
        cs = 0;
        repeat (4) tick();
    endtask

    task automatic model_frame(input logic [7:0] c, input logic [7:0] x, input logic [7:0] y);
        int op;
        op = int'(c[7:4]);
        if (op == 1 && int'(x) < GW && int'(y) < GH) exp_q.push_back({AW'(int'(y) * GW + int'(x)), c[3:0]});
        else if (op == 2) for (int a = 0; a < GW * GH; a++) exp_q.push_back({AW'(a), c[3:0]});
        else if (op == 3) exp_score = {x, y};
        else if (op != 0) exp_bad = exp_bad < 255 ? exp_bad + 1 : 255;
    endtask

    function automatic int first_diff();
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= log_q.size() || log_q[i] !== exp_q[i]) return i;
        if (log_q.size() > exp_q.size()) return exp_q.size();
        return -1;
    endfunction

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || wr_valid) && n < 4000) begin
            tick();
            n++;
        end
        total++; if (n >= 4000) begin bad++; $display("FAIL %s_timeout busy=%0b want=0", name, busy); end
    endtask

    task automatic clear_queues();
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        nreset = 0; cs = 0; ready_mode = 0; ready_hold = 0;
        repeat (3) tick();
        total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", wr_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%0b want=0", overrun); end
        total++; if (score !== 16'h0) begin bad++; $display("FAIL reset_score got=%0h want=0", score); end
        total++; if (bad_cmd_count !== 8'h0) begin bad++; $display("FAIL reset_badcnt got=%0d want=0", bad_cmd_count); end
        total++; if (wr_addr !== '0 || wr_data !== 4'h0) begin bad++; $display("FAIL reset_addr_data got=%0d/%0h want=0/0", wr_addr, wr_data); end
        nreset = 1;
        tick();
    endtask

    task automatic test_write_tile();
        ready_hold = 1;
        repeat (2) tick();
        clear_queues();
        cs = 1; command = 8'h15; databyte1 = 8'd3; databyte2 = 8'd2;
        repeat (3) tick();
        cs = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            total++; if (wr_valid !== 1'(k == 5)) begin bad++; $display("FAIL wt_latency edge=%0d got=%0b want=%0b", k, wr_valid, k == 5); end
            if (k == 5) begin
                total++; if (wr_addr !== AW'(67) || wr_data !== 4'h5) begin bad++; $display("FAIL wt_addr_data got=%0d/%0h want=67/5", wr_addr, wr_data); end
            end
        end
        model_frame(8'h15, 8'd3, 8'd2);
        total++; if (first_diff() != -1) begin bad++; $display("FAIL wt_log got_size=%0d want_size=%0d", log_q.size(), exp_q.size()); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wt_busy got=%0b want=0", busy); end
    endtask

    task automatic test_set_score();
        clear_queues();
        send_frame(8'h30, 8'h12, 8'h34);
        model_frame(8'h30, 8'h12, 8'h34);
        wait_idle("score");
        total++; if (score !== 16'h1234 || score !== exp_score) begin bad++; $display("FAIL score_val got=%0h want=%0h", score, exp_score); end
        total++; if (bad_cmd_count !== 8'(exp_bad)) begin bad++; $display("FAIL score_badcnt got=%0d want=%0d", bad_cmd_count, exp_bad); end
        total++; if (log_q.size() != 0) begin bad++; $display("FAIL score_nowrite got=%0d want=0", log_q.size()); end
    endtask

    task automatic test_clear();
        logic pv, pr;
        logic [AW-1:0] pa;
        logic [3:0] pd;
        int stalls, unstable, n;
        pv = 0; pr = 0; pa = '0; pd = '0; stalls = 0; unstable = 0; n = 0;
        clear_queues();
        ready_mode = 2;
        send_frame(8'h27, 8'h0, 8'h0);
        model_frame(8'h27, 8'h0, 8'h0);
        while ((busy || wr_valid) && n < 4000) begin
            @(negedge clk);
            n++;
            if (pv && !pr) begin
                stalls++;
                if (!wr_valid || wr_addr !== pa || wr_data !== pd) unstable++;
            end
            pv = wr_valid; pr = wr_ready; pa = wr_addr; pd = wr_data;
        end
        ready_mode = 0; ready_hold = 1;
        tick();
        total++; if (n >= 4000) begin bad++; $display("FAIL clear_timeout cycles=%0d want<4000", n); end
        total++; if (unstable != 0 || stalls == 0) begin bad++; $display("FAIL clear_stall_hold unstable=%0d stalls=%0d want 0 and >0", unstable, stalls); end
        total++; if (log_q.size() != 768) begin bad++; $display("FAIL clear_count got=%0d want=768", log_q.size()); end
        total++; if (first_diff() != -1) begin bad++; $display("FAIL clear_order idx=%0d got_size=%0d want_size=%0d", first_diff(), log_q.size(), exp_q.size()); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL clear_idle got=%0b want=0", busy); end
    endtask

    task automatic test_bad();
        logic [7:0] c;
        clear_queues();
        send_frame(8'h90, 8'h0, 8'h0);  model_frame(8'h90, 8'h0, 8'h0);
        send_frame(8'h11, 8'd32, 8'd0); model_frame(8'h11, 8'd32, 8'd0);
        send_frame(8'h11, 8'd0, 8'd24); model_frame(8'h11, 8'd0, 8'd24);
        wait_idle("bad");
        total++; if (bad_cmd_count !== 8'd3 || exp_bad != 3) begin bad++; $display("FAIL bad_count3 got=%0d want=3", bad_cmd_count); end
        total++; if (log_q.size() != 0) begin bad++; $display("FAIL bad_nowrite got=%0d want=0", log_q.size()); end
        for (int i = 0; i < 252; i++) begin
            c = {4'($urandom_range(4, 15)), 4'($urandom)};
            send_frame(c, 8'($urandom), 8'($urandom));
            model_frame(c, 8'h0, 8'h0);
        end
        total++; if (bad_cmd_count !== 8'(exp_bad)) begin bad++; $display("FAIL bad_count255 got=%0d want=%0d", bad_cmd_count, exp_bad); end
        for (int i = 0; i < 5; i++) begin
            send_frame(8'hF3, 8'h0, 8'h0);
            model_frame(8'hF3, 8'h0, 8'h0);
        end
        total++; if (bad_cmd_count !== 8'd255 || exp_bad != 255) begin bad++; $display("FAIL bad_saturate got=%0d want=255", bad_cmd_count); end
    endtask

    task automatic test_overrun();
        clear_queues();
        ready_hold = 0;
        repeat (2) tick();
        send_frame(8'h23, 8'h0, 8'h0); model_frame(8'h23, 8'h0, 8'h0);
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_early got=%0b want=0", overrun); end
        send_frame(8'h1A, 8'd5, 8'd6); model_frame(8'h1A, 8'd5, 8'd6);
        total++; if (overrun !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL ovr_pending overrun=%0b busy=%0b want 0/1", overrun, busy); end
        send_frame(8'h1B, 8'd7, 8'd8);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_drop got=%0b want=1", overrun); end
        total++; if (log_q.size() != 0) begin bad++; $display("FAIL ovr_stalled got=%0d want=0", log_q.size()); end
        ready_hold = 1;
        wait_idle("ovr");
        total++; if (log_q.size() != 769) begin bad++; $display("FAIL ovr_count got=%0d want=769", log_q.size()); end
        total++; if (first_diff() != -1) begin bad++; $display("FAIL ovr_order idx=%0d got_size=%0d want_size=%0d", first_diff(), log_q.size(), exp_q.size()); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%0b want=1", overrun); end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        clear_queues();
        ready_hold = 1;
        send_frame(8'h25, 8'h0, 8'h0);
        for (n = 0; n < 2000 && !(wr_valid && wr_ready && wr_addr == AW'(99)); n++) @(negedge clk);
        @(posedge clk);
        #1;
        nreset = 0; ready_hold = 0;
        tick();
        total++; if (n >= 2000) begin bad++; $display("FAIL rst_mid_reach cycles=%0d want<2000", n); end
        total++; if (wr_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid_valid_busy got=%0b/%0b want=0/0", wr_valid, busy); end
        total++; if (score !== 16'h0 || overrun !== 1'b0) begin bad++; $display("FAIL rst_mid_score_ovr got=%0h/%0b want=0/0", score, overrun); end
        total++; if (bad_cmd_count !== 8'h0) begin bad++; $display("FAIL rst_mid_badcnt got=%0d want=0", bad_cmd_count); end
        nreset = 1; ready_hold = 1;
        exp_score = 0; exp_bad = 0;
        repeat (30) tick();
        total++; if (log_q.size() != 100 || wr_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_nowrite got=%0d/%0b want=100/0", log_q.size(), wr_valid); end
    endtask

    task automatic test_random();
        int r, clears;
        logic [7:0] c, x, y;
        clears = 0;
        clear_queues();
        ready_mode = 1;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            x = 8'($urandom_range(0, 35));
            y = 8'($urandom_range(0, 27));
            c = 8'($urandom);
            if (r == 0) c[7:4] = 4'h0;
            else if (r <= 4) c[7:4] = 4'h1;
            else if (r == 5 && clears < 2) begin c[7:4] = 4'h2; clears++; end
            else if (r <= 7) c[7:4] = 4'h3;
            else c[7:4] = 4'($urandom_range(4, 15));
            send_frame(c, x, y);
            model_frame(c, x, y);
            wait_idle("rand");
        end
        ready_mode = 0;
        total++; if (first_diff() != -1) begin bad++; $display("FAIL rand_writes idx=%0d got_size=%0d want_size=%0d", first_diff(), log_q.size(), exp_q.size()); end
        total++; if (score !== exp_score) begin bad++; $display("FAIL rand_score got=%0h want=%0h", score, exp_score); end
        total++; if (bad_cmd_count !== 8'(exp_bad)) begin bad++; $display("FAIL rand_badcnt got=%0d want=%0d", bad_cmd_count, exp_bad); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rand_overrun got=%0b want=0", overrun); end
    endtask

    initial begin
        test_reset();
        test_write_tile();
        test_set_score();
        test_clear();
        test_bad();
        test_overrun();
        test_reset_mid_clear();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_cmd_ctrl.md
Name: spi_cmd_ctrl

Overview:
- Command sequencer between the SPI receive shift register (sck domain) and the tile framebuffer write port (clk domain).
- Synchronizes frame end (cs falling), captures the 3-byte frame (command, databyte1, databyte2), decodes it and issues framebuffer writes over a valid/ready handshake.
- Multi-cycle commands (CLEAR) are sequenced internally; one frame is buffered while busy.

Parameters:
- GRID_W, 32, tiles per row.
- GRID_H, 24, tile rows.
- ADDR_W, 10, framebuffer address width; must satisfy 2**ADDR_W >= GRID_W*GRID_H.

Ports:
- clk  input  1  system clock.
- nreset  input  1  synchronous active-low reset.
- cs  input  1  SPI chip select, asynchronous to clk, high during a frame.
- command  input  8  received byte 0; stable while cs low.
- databyte1  input  8  received byte 1 (x); stable while cs low.
- databyte2  input  8  received byte 2 (y); stable while cs low.
- wr_valid  output  1  framebuffer write request.
- wr_ready  input  1  framebuffer accepts write when high with wr_valid.
- wr_addr  output  ADDR_W  tile address = y*GRID_W + x.
- wr_data  output  4  tile value.
- score  output  16  score register.
- busy  output  1  high when state != IDLE or pending frame held.
- overrun  output  1  sticky: frame dropped.
- bad_cmd_count  output  8  saturating count of rejected frames.

Behaviour:
- Reset (nreset low at posedge clk): state=IDLE, wr_valid=0, wr_addr=0, wr_data=0, score=0, busy=0, overrun=0, bad_cmd_count=0, pending empty, synchronizer flops=0. Applies mid-write or mid-CLEAR: the operation is abandoned and wr_valid is low after that edge.
- cs passes through a 2-flop synchronizer. A frame event is sync'd cs 1->0, detected on the 3rd clk edge after cs falls. Bytes are sampled into a frame register on that edge. Senders must keep cs low >= 4 clk periods between frames; otherwise behaviour is undefined.
- Opcode = command[7:4], val = command[3:0]:
  - 0x0 NOP: no action.
  - 0x1 WRITE_TILE: one write, addr = databyte2*GRID_W + databyte1, data = val.
  - 0x2 CLEAR: writes val to addresses 0..GRID_W*GRID_H-1, ascending.
  - 0x3 SET_SCORE: score <= {databyte1, databyte2}.
  - 0x4-0xF: bad.
- WRITE_TILE with databyte1 >= GRID_W or databyte2 >= GRID_H is bad: no write.
- Bad frame: bad_cmd_count += 1, saturating at 255.
- FSM states:
  - IDLE: frame event, or pending frame present -> DECODE; the pending frame has priority over a same-cycle new event, and the new event then fills pending.
  - DECODE (1 cycle): NOP, SET_SCORE and bad frames -> IDLE. score updates on the DECODE->IDLE edge. WRITE_TILE -> WRITE. CLEAR -> CLEAR with address counter=0.
  - WRITE: wr_valid=1; on wr_valid&&wr_ready -> IDLE, wr_valid low next cycle.
  - CLEAR: wr_valid=1; on accept, counter+1. If the accepted address was GRID_W*GRID_H-1, go to IDLE.
- Latency: a WRITE_TILE frame event at edge N gives wr_valid high after edge N+2 with wr_ready=1.
- Throughput: 1 write/cycle in CLEAR with wr_ready held high. CLEAR of 32x24 = 768 accepted writes.
- Handshake: while wr_valid=1 and wr_ready=0, wr_addr and wr_data hold stable; wr_valid never drops without an accept except on reset.
- Buffering: a frame event while state != IDLE, or in IDLE with pending being consumed, loads the 1-deep pending register. If pending is already full, the new frame is dropped and overrun <= 1 until reset.
- Address arithmetic is done at ADDR_W bits; no wrap occurs given the range check.

Decomposition:
- Package snake_pkg holds:
  - opcode enum (OP_NOP, OP_WRITE_TILE, OP_CLEAR, OP_SET_SCORE);
  - state enum (S_IDLE, S_DECODE, S_WRITE, S_CLEAR);
  - frame struct {command, databyte1, databyte2};
  - GRID_W/GRID_H defaults.
- Sub-module sync_fall: 2-flop synchronizer plus falling-edge pulse, with nreset.

Test Plan:
- WRITE_TILE cmd=0x15, x=3, y=2, wr_ready=1 -> one accept with wr_addr=67, wr_data=5; wr_valid high 1 cycle, starting 2 cycles after the frame event; busy low afterwards.
- SET_SCORE cmd=0x30, db1=0x12, db2=0x34 -> score=0x1234; no wr_valid; bad_cmd_count=0.
- CLEAR cmd=0x27 with wr_ready toggling 1/0 -> exactly 768 accepts, addresses 0..767 in order, data=7, addr/data stable across stalls; then IDLE.
- Bad frames: cmd=0x90, then WRITE_TILE x=32 y=0, then x=0 y=24 -> bad_cmd_count=3, no writes. 260 bad frames -> count saturates at 255.
- Overrun: CLEAR with wr_ready=0, then two WRITE_TILE frames -> the first is pending and the second is dropped with overrun=1. Release wr_ready -> 768 clear writes, then the first WRITE_TILE executes.
- Reset mid-CLEAR after 100 accepts with nreset=0 for 1 cycle -> wr_valid=0, busy=0, score=0, overrun=0 next edge; no further writes.
